// File: rtl/fetch_unit_pkg.sv
// Shared widths, fetch-address layout and the line word-select helper for the fetch stage.
// Vectors are declared [N-1:0]: big-endian bit i of a field is bit N-1-i here, so
// word 0 (bits [0:31]) is the most significant word of a line, and offset[0:2] is offset[4:2].
package fetch_unit_pkg;

  localparam int TAG_W          = 51;
  localparam int INDEX_W        = 8;
  localparam int OFFSET_W       = 5;
  localparam int LINE_W         = 256;
  localparam int INSTR_W        = 32;
  localparam int NUM_LINES      = 1 << INDEX_W;
  localparam int WORD_SEL_W     = 3;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } fetch_addr_t;

  // Word 0 sits in the most significant 32 bits of the line.
  function automatic logic [INSTR_W-1:0] line_word(input logic [LINE_W-1:0]     line,
                                                   input logic [WORD_SEL_W-1:0] sel);
    return line[LINE_W - INSTR_W * (int'(sel) + 1) +: INSTR_W];
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction cache storage: valid bits, tags and line data.
// One registered read port (read-before-write on a same-index collision) and one write port.
module icache_array
  import fetch_unit_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_rd_en,
  input  logic [INDEX_W-1:0] i_rd_index,
  output logic               o_rd_valid,
  output logic [TAG_W-1:0]   o_rd_tag,
  output logic [LINE_W-1:0]  o_rd_line,
  input  logic               i_wr_en,
  input  logic [INDEX_W-1:0] i_wr_index,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [LINE_W-1:0]  i_wr_line
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    r_data_mem [NUM_LINES];
  logic                 r_rd_valid;
  logic [TAG_W-1:0]     r_rd_tag;
  logic [LINE_W-1:0]    r_rd_line;

  // Valid bits: cleared by reset, set by each refill write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag and data storage, written on refill; never reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag_mem[i_wr_index]  <= i_wr_tag;
      r_data_mem[i_wr_index] <= i_wr_line;
    end
  end

  // Registered read of the valid bit; reset so a pending hit cannot survive reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_valid <= 1'b0;
    end else if (i_rd_en) begin
      r_rd_valid <= r_valid[i_rd_index];
    end
  end

  // Registered read of tag and line; nonblocking update gives pre-write contents on collision.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rd_tag  <= r_tag_mem[i_rd_index];
      r_rd_line <= r_data_mem[i_rd_index];
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_tag   = r_rd_tag;
  assign o_rd_line  = r_rd_line;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: S1 latches the request, S2 reads the cache line,
// S3 compares tags, and the output register emits a one-cycle hit or miss pulse.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                flushPipleine_i,
  input  logic                enable_i,
  input  logic [TAG_W-1:0]    tag_i,
  input  logic [INDEX_W-1:0]  index_i,
  input  logic [OFFSET_W-1:0] offset_i,
  input  logic [TAG_W-1:0]    newTag_i,
  input  logic [INDEX_W-1:0]  newIndex_i,
  input  logic [OFFSET_W-1:0] newOffset_i,
  input  logic [LINE_W-1:0]   newCacheline_i,
  input  logic                cacheUpdateEnable_i,
  output logic [TAG_W-1:0]    tag_o,
  output logic [INDEX_W-1:0]  index_o,
  output logic [OFFSET_W-1:0] offset_o,
  output logic [INSTR_W-1:0]  fetchedInstruction_o,
  output logic                enable_o,
  output logic [TAG_W-1:0]    newTag_o,
  output logic [INDEX_W-1:0]  newIndex_o,
  output logic [OFFSET_W-1:0] newOffset_o,
  output logic                isCacheMiss_o
);

  fetch_addr_t         w_req;
  fetch_addr_t         r_s1_addr;
  fetch_addr_t         r_s2_addr;
  fetch_addr_t         r_s3_addr;
  logic                r_s1_vld;
  logic                r_s2_vld;
  logic                r_s3_vld;

  logic                w_rd_valid;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [LINE_W-1:0]   w_rd_line;
  logic [INSTR_W-1:0]  w_s2_word;

  logic                r_s3_line_vld;
  logic [TAG_W-1:0]    r_s3_tag;
  logic [INSTR_W-1:0]  r_s3_word;
  logic                w_s3_hit;

  logic                r_enable;
  logic                r_miss;
  fetch_addr_t         r_hit_addr;
  fetch_addr_t         r_miss_addr;
  logic [INSTR_W-1:0]  r_instr;

  // The refill offset carries no information: whole lines are written.
  logic                w_unused_new_offset;
  assign w_unused_new_offset = ^newOffset_i;

  assign w_req = {tag_i, index_i, offset_i};

  icache_array u_icache_array (
    .i_clk      (clock_i),
    .i_rst_n    (reset_i),
    .i_rd_en    (r_s1_vld),
    .i_rd_index (r_s1_addr.index),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_line  (w_rd_line),
    .i_wr_en    (cacheUpdateEnable_i),
    .i_wr_index (newIndex_i),
    .i_wr_tag   (newTag_i),
    .i_wr_line  (newCacheline_i)
  );

  // Word select happens on the S2 read data so S3 only carries one instruction.
  assign w_s2_word = line_word(w_rd_line, r_s2_addr.offset[OFFSET_W-1 -: WORD_SEL_W]);

  // Stage valid flags: flush wins over a new request and kills everything in flight.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
    end else if (flushPipleine_i) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
    end else begin
      r_s1_vld <= enable_i;
      r_s2_vld <= r_s1_vld;
      r_s3_vld <= r_s2_vld;
    end
  end

  // Stage payloads; only meaningful while the matching valid flag is set.
  always_ff @(posedge clock_i) begin
    if (enable_i) begin
      r_s1_addr <= w_req;
    end
    r_s2_addr     <= r_s1_addr;
    r_s3_addr     <= r_s2_addr;
    r_s3_line_vld <= w_rd_valid;
    r_s3_tag      <= w_rd_tag;
    r_s3_word     <= w_s2_word;
  end

  // S3 tag compare.
  always_comb begin
    w_s3_hit = r_s3_line_vld && (r_s3_tag == r_s3_addr.tag);
  end

  // Output register: one-cycle pulses, data fields hold until the next hit or miss.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_enable    <= 1'b0;
      r_miss      <= 1'b0;
      r_hit_addr  <= '0;
      r_miss_addr <= '0;
      r_instr     <= '0;
    end else begin
      r_enable <= 1'b0;
      r_miss   <= 1'b0;
      if (!flushPipleine_i && r_s3_vld) begin
        if (w_s3_hit) begin
          r_enable   <= 1'b1;
          r_hit_addr <= r_s3_addr;
          r_instr    <= r_s3_word;
        end else begin
          r_miss      <= 1'b1;
          r_miss_addr <= r_s3_addr;
        end
      end
    end
  end

  assign enable_o             = r_enable;
  assign isCacheMiss_o        = r_miss;
  assign tag_o                = r_hit_addr.tag;
  assign index_o              = r_hit_addr.index;
  assign offset_o             = r_hit_addr.offset;
  assign fetchedInstruction_o = r_instr;
  assign newTag_o             = r_miss_addr.tag;
  assign newIndex_o           = r_miss_addr.index;
  assign newOffset_o          = r_miss_addr.offset;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven fetch vectors scored through an
// expectation queue, plus hand-written flush, collision and asynchronous-reset sequences.
module tb_fetch_unit;

  logic         clock_i = 1'b0;
  logic         reset_i = 1'b0;
  logic         flushPipleine_i = 1'b0;
  logic         enable_i = 1'b0;
  logic [50:0]  tag_i = '0;
  logic [7:0]   index_i = '0;
  logic [4:0]   offset_i = '0;
  logic [50:0]  newTag_i = '0;
  logic [7:0]   newIndex_i = '0;
  logic [4:0]   newOffset_i = '0;
  logic [255:0] newCacheline_i = '0;
  logic         cacheUpdateEnable_i = 1'b0;
  logic [50:0]  tag_o;
  logic [7:0]   index_o;
  logic [4:0]   offset_o;
  logic [31:0]  fetchedInstruction_o;
  logic         enable_o;
  logic [50:0]  newTag_o;
  logic [7:0]   newIndex_o;
  logic [4:0]   newOffset_o;
  logic         isCacheMiss_o;

  fetch_unit dut (
    .clock_i              (clock_i),
    .reset_i              (reset_i),
    .flushPipleine_i      (flushPipleine_i),
    .enable_i             (enable_i),
    .tag_i                (tag_i),
    .index_i              (index_i),
    .offset_i             (offset_i),
    .newTag_i             (newTag_i),
    .newIndex_i           (newIndex_i),
    .newOffset_i          (newOffset_i),
    .newCacheline_i       (newCacheline_i),
    .cacheUpdateEnable_i  (cacheUpdateEnable_i),
    .tag_o                (tag_o),
    .index_o              (index_o),
    .offset_o             (offset_o),
    .fetchedInstruction_o (fetchedInstruction_o),
    .enable_o             (enable_o),
    .newTag_o             (newTag_o),
    .newIndex_o           (newIndex_o),
    .newOffset_o          (newOffset_o),
    .isCacheMiss_o        (isCacheMiss_o)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [50:0] tag;
    logic [7:0]  idx;
    logic [4:0]  off;
    bit          hit;
    logic [31:0] instr;
  } vec_t;

  typedef struct {
    int          due;
    bit          hit;
    logic [50:0] tag;
    logic [7:0]  idx;
    logic [4:0]  off;
    logic [31:0] instr;
  } exp_t;

  exp_t q[$];
  vec_t tbl[13];

  logic [255:0] line_a = 256'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA_99999999_88888888;
  logic [255:0] line_b = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare the oldest expectation when it falls due; any other pulse is stray.
  always @(negedge clock_i) begin
    if (reset_i) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        void'(q.pop_front());
        check("late_result", 64'(cyc), 64'(q.size()));
      end else if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        if (e.hit) begin
          check("hit_en", 64'(enable_o), 64'd1);
          check("hit_miss", 64'(isCacheMiss_o), 64'd0);
          check("hit_instr", 64'(fetchedInstruction_o), 64'(e.instr));
          check("hit_tag", 64'(tag_o), 64'(e.tag));
          check("hit_index", 64'(index_o), 64'(e.idx));
          check("hit_offset", 64'(offset_o), 64'(e.off));
        end else begin
          check("miss_flag", 64'(isCacheMiss_o), 64'd1);
          check("miss_en", 64'(enable_o), 64'd0);
          check("miss_tag", 64'(newTag_o), 64'(e.tag));
          check("miss_index", 64'(newIndex_o), 64'(e.idx));
          check("miss_offset", 64'(newOffset_o), 64'(e.off));
        end
      end else if (enable_o || isCacheMiss_o) begin
        check("stray_pulse", {62'd0, enable_o, isCacheMiss_o}, 64'd0);
      end
    end
  end

  task automatic fetch(input logic [50:0] t, input logic [7:0] i, input logic [4:0] o,
                       input bit push, input bit hit, input logic [31:0] instr);
    @(negedge clock_i);
    enable_i = 1'b1;
    tag_i    = t;
    index_i  = i;
    offset_i = o;
    if (push) q.push_back('{due: cyc + 4, hit: hit, tag: t, idx: i, off: o, instr: instr});
  endtask

  task automatic idle();
    @(negedge clock_i);
    enable_i = 1'b0;
  endtask

  task automatic refill(input logic [50:0] t, input logic [7:0] i, input logic [255:0] line,
                        input bit with_flush);
    @(negedge clock_i);
    cacheUpdateEnable_i = 1'b1;
    newTag_i            = t;
    newIndex_i          = i;
    newOffset_i         = 5'h1F;
    newCacheline_i      = line;
    flushPipleine_i     = with_flush;
    @(negedge clock_i);
    cacheUpdateEnable_i = 1'b0;
    flushPipleine_i     = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) begin
      @(negedge clock_i);
      #1;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      q.delete();
    end
  endtask

  task automatic expect_quiet(input int n);
    repeat (n) begin
      @(negedge clock_i);
      #1;
      check("quiet_en", 64'(enable_o), 64'd0);
      check("quiet_miss", 64'(isCacheMiss_o), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{51'd5, 8'd8, 5'd8,  1'b1, 32'hDDDDDDDD};
    tbl[1]  = '{51'd5, 8'd8, 5'd0,  1'b1, 32'hFFFFFFFF};
    tbl[2]  = '{51'd5, 8'd8, 5'd4,  1'b1, 32'hEEEEEEEE};
    tbl[3]  = '{51'd5, 8'd8, 5'd8,  1'b1, 32'hDDDDDDDD};
    tbl[4]  = '{51'd5, 8'd8, 5'd16, 1'b1, 32'hBBBBBBBB};
    tbl[5]  = '{51'd5, 8'd8, 5'd20, 1'b1, 32'hAAAAAAAA};
    tbl[6]  = '{51'd5, 8'd8, 5'd24, 1'b1, 32'h99999999};
    tbl[7]  = '{51'd5, 8'd8, 5'd28, 1'b1, 32'h88888888};
    tbl[8]  = '{51'd6, 8'd8, 5'd0,  1'b0, 32'h0};
    tbl[9]  = '{51'd5, 8'd9, 5'd0,  1'b0, 32'h0};
    tbl[10] = '{51'd5, 8'd8, 5'd13, 1'b1, 32'hCCCCCCCC};
    tbl[11] = '{51'd5, 8'd8, 5'd30, 1'b1, 32'h88888888};
    tbl[12] = '{51'h7_FFFF_FFFF_FFFF, 8'd8, 5'd0, 1'b0, 32'h0};

    // Reset state.
    #1;
    check("rst_en", 64'(enable_o), 64'd0);
    check("rst_miss", 64'(isCacheMiss_o), 64'd0);
    check("rst_instr", 64'(fetchedInstruction_o), 64'd0);
    check("rst_tag", 64'(tag_o), 64'd0);
    check("rst_newtag", 64'(newTag_o), 64'd0);
    repeat (3) @(negedge clock_i);
    reset_i = 1'b1;

    // Cold miss, then both pulses low afterwards.
    fetch(51'd5, 8'd8, 5'd4, 1'b1, 1'b0, 32'h0);
    idle();
    drain();
    expect_quiet(2);

    // Refill and table-driven fetch stream, back-to-back.
    refill(51'd5, 8'd8, line_a, 1'b0);
    for (int i = 0; i < 13; i++) fetch(tbl[i].tag, tbl[i].idx, tbl[i].off, 1'b1, tbl[i].hit,
                                       tbl[i].instr);
    idle();
    drain();
    expect_quiet(2);

    // Refill to the index being read in S2 on the same edge: read returns old contents.
    fetch(51'd7, 8'd10, 5'd0, 1'b1, 1'b0, 32'h0);
    @(negedge clock_i);
    enable_i            = 1'b0;
    cacheUpdateEnable_i = 1'b1;
    newTag_i            = 51'd7;
    newIndex_i          = 8'd10;
    newCacheline_i      = line_b;
    @(negedge clock_i);
    cacheUpdateEnable_i = 1'b0;
    fetch(51'd7, 8'd10, 5'd4, 1'b1, 1'b1, 32'h22222222);
    idle();
    drain();

    // Flush one edge after a hitting request: no pulse, contents kept.
    fetch(51'd5, 8'd8, 5'd8, 1'b0, 1'b0, 32'h0);
    @(negedge clock_i);
    enable_i        = 1'b0;
    flushPipleine_i = 1'b1;
    @(negedge clock_i);
    flushPipleine_i = 1'b0;
    expect_quiet(4);
    fetch(51'd5, 8'd8, 5'd8, 1'b1, 1'b1, 32'hDDDDDDDD);
    idle();
    drain();

    // Flush and request on the same edge: request discarded.
    @(negedge clock_i);
    enable_i        = 1'b1;
    tag_i           = 51'd5;
    index_i         = 8'd8;
    offset_i        = 5'd0;
    flushPipleine_i = 1'b1;
    @(negedge clock_i);
    enable_i        = 1'b0;
    flushPipleine_i = 1'b0;
    expect_quiet(4);

    // Flush and refill on the same edge: the write still lands.
    refill(51'd9, 8'd11, line_b, 1'b1);
    fetch(51'd9, 8'd11, 5'd28, 1'b1, 1'b1, 32'h88888888);
    idle();
    drain();

    // Asynchronous reset with requests in flight.
    fetch(51'd5, 8'd8, 5'd0, 1'b1, 1'b1, 32'hFFFFFFFF);
    fetch(51'd5, 8'd8, 5'd4, 1'b1, 1'b1, 32'hEEEEEEEE);
    fetch(51'd5, 8'd8, 5'd8, 1'b1, 1'b1, 32'hDDDDDDDD);
    fetch(51'd5, 8'd8, 5'd16, 1'b1, 1'b1, 32'hBBBBBBBB);
    @(posedge clock_i);
    #1 enable_i = 1'b0;
    #1;
    check("pre_reset_pulse", 64'(enable_o), 64'd1);
    reset_i = 1'b0;
    q.delete();
    #1;
    check("async_rst_en", 64'(enable_o), 64'd0);
    check("async_rst_instr", 64'(fetchedInstruction_o), 64'd0);
    check("async_rst_tag", 64'(tag_o), 64'd0);
    check("async_rst_miss", 64'(isCacheMiss_o), 64'd0);
    @(negedge clock_i);
    reset_i = 1'b1;
    expect_quiet(4);
    fetch(51'd5, 8'd8, 5'd8, 1'b1, 1'b0, 32'h0);
    idle();
    drain();
    expect_quiet(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage with an integrated direct-mapped, 256-line instruction cache (32-byte lines, 32-bit instructions). It sits at the front of the pipeline. A 64-bit fetch address arrives split into tag, index and offset; the block returns the addressed instruction on a hit, or flags a miss and exports the address for the refill path. Refills arrive on a separate update port. All vectors use big-endian bit numbering [0:N-1].

## Interface
- TAG_W, 51, tag width
- INDEX_W, 8, index width (2^8 lines)
- OFFSET_W, 5, byte offset within a line
- LINE_W, 256, cacheline width
- INSTR_W, 32, instruction width

Ports:
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-low
- flushPipleine_i  in  1  synchronous flush of in-flight requests
- enable_i  in  1  fetch request valid
- tag_i / index_i / offset_i  in  51 / 8 / 5  fetch address
- newTag_i / newIndex_i / newOffset_i  in  51 / 8 / 5  refill address
- newCacheline_i  in  256  refill data
- cacheUpdateEnable_i  in  1  write the refill line
- tag_o / index_o / offset_o  out  51 / 8 / 5  address of the returned instruction
- fetchedInstruction_o  out  32  fetched instruction
- enable_o  out  1  instruction output valid (one-cycle pulse per hit)
- newTag_o / newIndex_o / newOffset_o  out  51 / 8 / 5  missed address
- isCacheMiss_o  out  1  miss valid (one-cycle pulse per miss)

## Operation
- Storage: per line, a valid bit, a 51-bit tag and 256 bits of data.
- Reset (reset_i low) does the following:
  - clears all valid bits and all pipeline valid flags;
  - drives every output to 0.
- Fetch is a three-register pipeline that accepts one request per cycle:
  - S1 latches the request.
  - S2 reads the valid bit, tag and line at index.
  - S3 compares the stored tag with the request tag.
- Hit (valid and tag equal) drives the output register as follows:
  - enable_o = 1;
  - tag_o, index_o and offset_o = the request address;
  - fetchedInstruction_o = line word offset[0:2].
- Word 0 is line bits [0:31]. offset[3:4] is ignored, so a misaligned offset returns the containing word.
- Miss drives the following:
  - isCacheMiss_o = 1;
  - newTag_o, newIndex_o and newOffset_o = the request address;
  - enable_o = 0.
- There is no stall and no internal refill; the block drops the missed request.
- When no valid request completes in a cycle, enable_o and isCacheMiss_o are 0.
- Data outputs hold their last value.
- cacheUpdateEnable_i at an edge writes the following to line newIndex_i:
  - tag = newTag_i;
  - data = newCacheline_i;
  - valid = 1.
- newOffset_i is ignored.
- Flush clears the S1–S3 valid flags. It keeps cache contents and suppresses any pulse that would have appeared after that edge.

## Timing
- The request is sampled at edge N.
- isCacheMiss_o or enable_o is visible after edge N+3 and lasts one cycle.
- Back-to-back requests produce back-to-back results in order.
- Refill and lookup of the same index in the same edge: the S2 read returns the pre-write contents (read-before-write). The new line is visible to S2 reads from edge +1.
- Flush and enable_i in the same edge: flush wins, and the request is discarded.
- Flush and cacheUpdateEnable_i in the same edge: the write still occurs.
- Asynchronous reset mid-operation clears the pipeline and valid bits immediately.

## Structure
- Shared package holds the following:
  - width constants TAG_W, INDEX_W, OFFSET_W, LINE_W, INSTR_W;
  - NUM_LINES = 256;
  - a fetch-address struct {tag, index, offset}.
- One natural sub-module, icache_array. It holds the valid, tag and data arrays, with one synchronous read port and one write port, and reset clearing the valid bits.
- Pipeline registers, hit compare and word select live in fetch_unit.

## Test plan
- Reset, then fetch tag=5, index=8, offset=4 -> after 3 edges isCacheMiss_o=1, newTag_o=5, newIndex_o=8, newOffset_o=4, enable_o=0. Both pulses are 0 the following cycle.
- Refill index 8, tag 5, line FFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA_99999999_88888888. Then fetch offset 8 -> enable_o=1, fetchedInstruction_o=DDDDDDDD, tag_o=5, index_o=8, offset_o=8.
- Consecutive fetches of offsets 0, 4, 8, 16, 20, 24, 28 on seven consecutive edges -> seven consecutive enable_o pulses returning FFFFFFFF, EEEEEEEE, DDDDDDDD, BBBBBBBB, AAAAAAAA, 99999999, 88888888. enable_o returns to 0 afterwards.
- Fetch index 8 with tag 6 after the refill -> miss. Fetch index 9 -> miss (valid=0).
- Issue a fetch hit, then assert flushPipleine_i one edge later -> no enable_o pulse. A subsequent fetch of the same address still hits.
- Assert reset_i low asynchronously between edges with requests in flight -> outputs go to 0 at once. Refetching index 8 then misses.
